// File: rtl/npc_fetch_ctrl.sv
// Next-PC unit for the F stage: fetch PC register, next-PC selection, stall hold
// with a latched redirect, exception/eret override and fetch address-error detect.
module npc_fetch_ctrl #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [WIDTH-1:0] IM_BASE    = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IM_LIMIT   = 32'h0000_6FFC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             b_taken,
    input  logic [WIDTH-1:0] b_target,
    input  logic             j,
    input  logic [WIDTH-1:0] j_target,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus8,
    output logic             fetch_adel,
    output logic             redirect_pending
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             redirect;
    logic [WIDTH-1:0] redir_tgt;

    assign redirect  = b_taken | j | jr;
    assign redir_tgt = b_taken ? b_target : (j ? j_target : jr_target);

    // exc/eret override everything including stall; a live redirect beats a latched one
    always_comb begin
        pc_d          = pc_q + WIDTH'(4);
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (exc_req) begin
            pc_d         = HANDLER_PC;
            pend_valid_d = 1'b0;
        end else if (eret) begin
            pc_d         = epc;
            pend_valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
            if (redirect) begin
                pend_valid_d  = 1'b1;
                pend_target_d = redir_tgt;
            end
        end else if (redirect) begin
            pc_d         = redir_tgt;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc               = pc_q;
    assign pc_plus8         = pc_q + WIDTH'(8);
    assign redirect_pending = pend_valid_q;
    assign fetch_adel       = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);

endmodule

// File: tb/tb_npc_fetch_ctrl.sv
// Self-checking bench for npc_fetch_ctrl: directed scenarios plus randomized
// cycles checked against a rule-level next-PC model.
module tb_npc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] HND_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset, stall, b_taken, j, jr, exc_req, eret;
    logic [31:0] b_target, j_target, jr_target, epc;
    logic [31:0] pc, pc_plus8;
    logic        fetch_adel, redirect_pending;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [31:0] m_pc;
    logic        m_pv;
    logic [31:0] m_pt;

    always #5 clk = ~clk;

    npc_fetch_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall),
        .b_taken(b_taken), .b_target(b_target),
        .j(j), .j_target(j_target),
        .jr(jr), .jr_target(jr_target),
        .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc(pc), .pc_plus8(pc_plus8),
        .fetch_adel(fetch_adel), .redirect_pending(redirect_pending)
    );

    function automatic logic adel_of(input logic [31:0] p);
        return (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6FFC);
    endfunction

    task automatic clear_inputs();
        reset = 0; stall = 0; b_taken = 0; j = 0; jr = 0; exc_req = 0; eret = 0;
        b_target = 0; j_target = 0; jr_target = 0; epc = 0;
    endtask

    // Advance one edge, apply the next-PC rules to the model, settle outputs.
    task automatic tick();
        logic        any_redir;
        logic [31:0] tgt;
        @(posedge clk);
        any_redir = b_taken || j || jr;
        if (b_taken)  tgt = b_target;
        else if (j)   tgt = j_target;
        else          tgt = jr_target;
        if (reset)        begin m_pc = RST_PC; m_pv = 0; end
        else if (exc_req) begin m_pc = HND_PC; m_pv = 0; end
        else if (eret)    begin m_pc = epc;    m_pv = 0; end
        else if (stall)   begin if (any_redir) begin m_pv = 1; m_pt = tgt; end end
        else if (any_redir) begin m_pc = tgt;  m_pv = 0; end
        else if (m_pv)    begin m_pc = m_pt;   m_pv = 0; end
        else              m_pc = m_pc + 32'd4;
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, RST_PC); end
        n_tests++;
        if (pc_plus8 !== RST_PC + 32'd8) begin n_fail++; $display("FAIL reset_pc8 got %h exp %h", pc_plus8, RST_PC + 32'd8); end
        n_tests++;
        if (fetch_adel !== 1'b0 || redirect_pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got adel=%b pend=%b exp 0 0", fetch_adel, redirect_pending);
        end
        $display("[TB] reset: pc=%h", pc);
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = RST_PC + 32'(4 * i);
            n_tests++;
            if (pc !== exp || pc_plus8 !== exp + 32'd8 || fetch_adel !== 1'b0) begin
                n_fail++; $display("FAIL seq%0d got pc=%h pc8=%h adel=%b exp pc=%h", i, pc, pc_plus8, fetch_adel, exp);
            end
            $display("[TB] seq: pc=%h", pc);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        repeat (4) tick();
        n_tests++;
        if (pc !== 32'h3010) begin n_fail++; $display("FAIL midrun_setup got %h exp 00003010", pc); end
        reset = 1; b_taken = 1; b_target = 32'h3400;
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== RST_PC || redirect_pending !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset got pc=%h pend=%b exp 00003000 0", pc, redirect_pending);
        end
        $display("[TB] midrun reset: pc=%h", pc);
    endtask

    task automatic test_redirect_priority();
        do_reset();
        repeat (2) tick();
        b_taken = 1; b_target = 32'h3100; j = 1; j_target = 32'h3200; jr = 1; jr_target = 32'h3300;
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== 32'h3100) begin n_fail++; $display("FAIL prio_b got %h exp 00003100", pc); end
        tick();
        n_tests++;
        if (pc !== 32'h3104) begin n_fail++; $display("FAIL prio_seq got %h exp 00003104", pc); end
        j = 1; j_target = 32'h3200; jr = 1; jr_target = 32'h3300;
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== 32'h3200) begin n_fail++; $display("FAIL prio_j got %h exp 00003200", pc); end
        $display("[TB] redirect priority: pc=%h", pc);
    endtask

    task automatic test_stall_pending();
        do_reset();
        repeat (4) tick();
        stall = 1; jr = 1; jr_target = 32'h3040;
        tick();
        jr = 0;
        n_tests++;
        if (pc !== 32'h3010 || redirect_pending !== 1'b1) begin
            n_fail++; $display("FAIL stall1 got pc=%h pend=%b exp 00003010 1", pc, redirect_pending);
        end
        tick();
        stall = 0;
        n_tests++;
        if (pc !== 32'h3010 || redirect_pending !== 1'b1) begin
            n_fail++; $display("FAIL stall2 got pc=%h pend=%b exp 00003010 1", pc, redirect_pending);
        end
        tick();
        n_tests++;
        if (pc !== 32'h3040 || redirect_pending !== 1'b0) begin
            n_fail++; $display("FAIL pend_release got pc=%h pend=%b exp 00003040 0", pc, redirect_pending);
        end
        // newer redirect during stall overwrites older; live redirect beats pending
        stall = 1; j = 1; j_target = 32'h3500;
        tick();
        j = 0; b_taken = 1; b_target = 32'h3600;
        tick();
        stall = 0; b_taken = 0; jr = 1; jr_target = 32'h3700;
        tick();
        jr = 0;
        n_tests++;
        if (pc !== 32'h3700 || redirect_pending !== 1'b0) begin
            n_fail++; $display("FAIL live_beats_pend got pc=%h pend=%b exp 00003700 0", pc, redirect_pending);
        end
        $display("[TB] stall/pending: pc=%h", pc);
    endtask

    task automatic test_exc_eret();
        do_reset();
        stall = 1; jr = 1; jr_target = 32'h3500;
        tick();
        jr = 0; exc_req = 1;
        tick();
        exc_req = 0; stall = 0;
        n_tests++;
        if (pc !== HND_PC || redirect_pending !== 1'b0) begin
            n_fail++; $display("FAIL exc got pc=%h pend=%b exp 00004180 0", pc, redirect_pending);
        end
        tick();
        n_tests++;
        if (pc !== 32'h4184) begin n_fail++; $display("FAIL exc_next got %h exp 00004184", pc); end
        eret = 1; epc = 32'h3014; stall = 1;
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== 32'h3014) begin n_fail++; $display("FAIL eret got %h exp 00003014", pc); end
        exc_req = 1; eret = 1; epc = 32'h3020;
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== HND_PC) begin n_fail++; $display("FAIL exc_vs_eret got %h exp 00004180", pc); end
        $display("[TB] exc/eret: pc=%h", pc);
    endtask

    task automatic test_adel_wrap();
        do_reset();
        jr = 1; jr_target = 32'h3002;
        tick(); clear_inputs();
        n_tests++;
        if (pc !== 32'h3002 || fetch_adel !== 1'b1) begin
            n_fail++; $display("FAIL adel_unaligned got pc=%h adel=%b exp 00003002 1", pc, fetch_adel);
        end
        j = 1; j_target = 32'h7000;
        tick(); clear_inputs();
        n_tests++;
        if (fetch_adel !== 1'b1) begin n_fail++; $display("FAIL adel_high got %b exp 1 (pc=%h)", fetch_adel, pc); end
        j = 1; j_target = 32'h6FFC;
        tick(); clear_inputs();
        n_tests++;
        if (fetch_adel !== 1'b0) begin n_fail++; $display("FAIL adel_limit got %b exp 0 (pc=%h)", fetch_adel, pc); end
        b_taken = 1; b_target = 32'h2FFC;
        tick(); clear_inputs();
        n_tests++;
        if (fetch_adel !== 1'b1) begin n_fail++; $display("FAIL adel_low got %b exp 1 (pc=%h)", fetch_adel, pc); end
        j = 1; j_target = 32'hFFFF_FFFC;
        tick(); clear_inputs();
        n_tests++;
        if (pc_plus8 !== 32'h4) begin n_fail++; $display("FAIL wrap_pc8 got %h exp 00000004", pc_plus8); end
        tick();
        n_tests++;
        if (pc !== 32'h0 || fetch_adel !== 1'b1) begin
            n_fail++; $display("FAIL wrap_pc got pc=%h adel=%b exp 00000000 1", pc, fetch_adel);
        end
        $display("[TB] adel/wrap: pc=%h", pc);
    endtask

    function automatic logic [31:0] rand_tgt();
        if ($urandom_range(0, 3) == 0) return $urandom();
        return 32'h3000 + 32'($urandom_range(0, 32'hFFF) * 4);
    endfunction

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 99) < 2);
            stall     = ($urandom_range(0, 99) < 35);
            b_taken   = ($urandom_range(0, 99) < 12);
            j         = ($urandom_range(0, 99) < 12);
            jr        = ($urandom_range(0, 99) < 12);
            exc_req   = ($urandom_range(0, 99) < 4);
            eret      = ($urandom_range(0, 99) < 4);
            b_target  = rand_tgt();
            j_target  = rand_tgt();
            jr_target = rand_tgt();
            epc       = rand_tgt();
            tick();
            n_tests++;
            if (pc !== m_pc || pc_plus8 !== m_pc + 32'd8 || fetch_adel !== adel_of(m_pc) ||
                redirect_pending !== m_pv) begin
                n_fail++;
                $display("FAIL rand%0d got pc=%h pc8=%h adel=%b pend=%b exp pc=%h pc8=%h adel=%b pend=%b",
                         i, pc, pc_plus8, fetch_adel, redirect_pending,
                         m_pc, m_pc + 32'd8, adel_of(m_pc), m_pv);
            end
            $display("[TB] rand%0d: pc=%h pend=%b", i, pc, redirect_pending);
        end
        clear_inputs();
    endtask

    initial begin
        m_pc = 0; m_pv = 0; m_pt = 0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_reset_midrun();
        test_redirect_priority();
        test_stall_pending();
        test_exc_eret();
        test_adel_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
